// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timing engine, leaderboard and display mux.
package stopwatch_pkg;

  localparam int TIME_W = 39;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode == MODE_SLOW) || (mode == MODE_FAST);
  endfunction

endpackage

// File: rtl/stopwatch_core_tick_prescaler.sv
// Divides clk down to a single-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
module tick_prescaler #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Run/stop timing engine: counts ticks while running and publishes a held result on stop.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int TIME_W  = stopwatch_pkg::TIME_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop,
  input  logic              clear,
  input  logic [1:0]        mode_sel,
  output logic [TIME_W-1:0] live_time,
  output logic              running,
  output logic [TIME_W-1:0] result_time,
  output logic [1:0]        result_mode,
  output logic              result_valid,
  output logic              overflow
);

  state_t            state, state_next;
  logic [1:0]        mode_q, mode_next;
  logic [TIME_W-1:0] live_next, live_inc;
  logic [TIME_W-1:0] result_time_next;
  logic [1:0]        result_mode_next;
  logic              result_valid_next;
  logic              overflow_next;
  logic              tick;
  logic              presc_reset;

  // Leaving RUN (stop or clear) zeroes the prescaler so it is already 0 on the next start.
  assign presc_reset = reset || clear || ((state == ST_RUN) && start_stop);

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .reset  (presc_reset),
    .enable (state == ST_RUN),
    .tick   (tick)
  );

  assign running  = (state == ST_RUN);
  assign live_inc = (&live_time) ? live_time : live_time + TIME_W'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next        = state;
    mode_next         = mode_q;
    live_next         = live_time;
    overflow_next     = overflow;
    result_time_next  = result_time;
    result_mode_next  = result_mode;
    result_valid_next = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start_stop && mode_valid(mode_sel)) begin
          state_next    = ST_RUN;
          mode_next     = mode_sel;
          live_next     = '0;
          overflow_next = 1'b0;
        end
      end
      ST_RUN: begin
        if (tick) begin
          live_next     = live_inc;
          overflow_next = overflow || (&live_inc);
        end
        if (start_stop) begin
          state_next        = ST_DONE;
          result_time_next  = tick ? live_inc : live_time;
          result_mode_next  = mode_q;
          result_valid_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Clear overrides everything, including a coincident stop, and leaves the last result alone.
    if (clear) begin
      state_next        = ST_IDLE;
      live_next         = '0;
      overflow_next     = 1'b0;
      result_time_next  = result_time;
      result_mode_next  = result_mode;
      result_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_NONE;
      live_time    <= '0;
      overflow     <= 1'b0;
      result_time  <= '0;
      result_mode  <= MODE_NONE;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      mode_q       <= mode_next;
      live_time    <= live_next;
      overflow     <= overflow_next;
      result_time  <= result_time_next;
      result_mode  <= result_mode_next;
      result_valid <= result_valid_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench: a 39-bit and a 4-bit stopwatch share stimulus with DIV = 10.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        reset, start_stop, clear;
  logic [1:0]  mode_sel;

  logic [38:0] w_live, w_result;
  logic [1:0]  w_mode;
  logic        w_running, w_valid, w_ovf;
  logic [3:0]  s_live, s_result;
  logic [1:0]  s_mode;
  logic        s_running, s_valid, s_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int vcount   = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.CLK_HZ(10), .TICK_HZ(1), .TIME_W(39)) dut_w (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .mode_sel(mode_sel),
    .live_time(w_live), .running(w_running), .result_time(w_result), .result_mode(w_mode),
    .result_valid(w_valid), .overflow(w_ovf)
  );

  stopwatch_core #(.CLK_HZ(10), .TICK_HZ(1), .TIME_W(4)) dut_s (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .mode_sel(mode_sel),
    .live_time(s_live), .running(s_running), .result_time(s_result), .result_mode(s_mode),
    .result_valid(s_valid), .overflow(s_ovf)
  );

  // Count result pulses of the wide instance, sampled mid-cycle.
  always @(negedge clk) if (w_valid) vcount++;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] alt;
    int         n;
    int         exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0;
    // start at cycle 0, stop at cycle n; ticks land on cycles 10,20,.. and a tick at n counts.
    vecs[0] = '{mode: 2'b01, alt: 2'b01, n: 35, exp: 3};
    vecs[1] = '{mode: 2'b10, alt: 2'b01, n: 20, exp: 2};
    vecs[2] = '{mode: 2'b10, alt: 2'b10, n: 9,  exp: 0};
    vecs[3] = '{mode: 2'b01, alt: 2'b01, n: 10, exp: 1};
    vecs[4] = '{mode: 2'b10, alt: 2'b11, n: 40, exp: 4};
    vecs[5] = '{mode: 2'b01, alt: 2'b00, n: 19, exp: 1};

    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; mode_sel = 2'b00;
    repeat (3) step();
    check("rst_live", w_live, 0);
    check("rst_running", w_running, 0);
    check("rst_result", w_result, 0);
    check("rst_mode", w_mode, 0);
    check("rst_valid", w_valid, 0);
    check("rst_ovf", w_ovf, 0);
    reset = 1'b0;
    step();

    // Invalid modes are ignored in IDLE.
    v0 = vcount;
    mode_sel = 2'b11; start_stop = 1'b1; step(); start_stop = 1'b0;
    check("inv11_running", w_running, 0);
    mode_sel = 2'b00; start_stop = 1'b1; step(); start_stop = 1'b0;
    check("inv00_running", w_running, 0);
    step();
    check("inv_no_valid", vcount - v0, 0);
    mode_sel = 2'b10; start_stop = 1'b1; step(); start_stop = 1'b0;
    check("valid_start_running", w_running, 1);
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_running", w_running, 0);
    check("clr_no_valid", vcount - v0, 0);

    for (int i = 0; i < 6; i++) begin
      v0 = vcount;
      mode_sel = vecs[i].mode; start_stop = 1'b1; step(); start_stop = 1'b0;
      mode_sel = vecs[i].alt;
      check($sformatf("v%0d_restart_live", i), w_live, 0);
      check($sformatf("v%0d_running", i), w_running, 1);
      repeat (vecs[i].n - 1) step();
      check($sformatf("v%0d_pre_valid", i), w_valid, 0);
      start_stop = 1'b1; step(); start_stop = 1'b0;
      check($sformatf("v%0d_valid", i), w_valid, 1);
      check($sformatf("v%0d_result", i), w_result, vecs[i].exp);
      check($sformatf("v%0d_rmode", i), w_mode, vecs[i].mode);
      check($sformatf("v%0d_s_result", i), s_result, vecs[i].exp);
      step();
      check($sformatf("v%0d_valid_drop", i), w_valid, 0);
      check($sformatf("v%0d_live_hold", i), w_live, vecs[i].exp);
      check($sformatf("v%0d_stopped", i), w_running, 0);
      check($sformatf("v%0d_pulses", i), vcount - v0, 1);
    end

    // Clear mid-run keeps the previous result (1, mode 01) and publishes nothing.
    v0 = vcount;
    mode_sel = 2'b10; start_stop = 1'b1; step(); start_stop = 1'b0;
    repeat (49) step();
    check("cm_live_before", w_live, 4);
    clear = 1'b1; step(); clear = 1'b0;
    check("cm_running", w_running, 0);
    check("cm_live", w_live, 0);
    check("cm_result", w_result, 1);
    check("cm_rmode", w_mode, 2'b01);
    repeat (3) step();
    check("cm_no_valid", vcount - v0, 0);

    // Clear and start_stop together from IDLE: clear wins.
    mode_sel = 2'b01; clear = 1'b1; start_stop = 1'b1; step(); clear = 1'b0; start_stop = 1'b0;
    check("cs_idle_running", w_running, 0);
    // Clear and stop together in RUN: no result.
    start_stop = 1'b1; step(); start_stop = 1'b0;
    repeat (14) step();
    clear = 1'b1; start_stop = 1'b1; step(); clear = 1'b0; start_stop = 1'b0;
    step();
    check("cs_run_running", w_running, 0);
    check("cs_run_no_valid", vcount - v0, 0);
    check("cs_run_result", w_result, 1);

    // Saturation of the 4-bit instance; stop lands on the tick at cycle 200.
    mode_sel = 2'b10; start_stop = 1'b1; step(); start_stop = 1'b0;
    repeat (149) step();
    check("sat_live_150", s_live, 14);
    repeat (50) step();
    check("sat_live_200", s_live, 15);
    check("sat_ovf", s_ovf, 1);
    check("wide_live_200", w_live, 19);
    check("wide_no_ovf", w_ovf, 0);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    check("sat_result", s_result, 15);
    check("wide_result", w_result, 20);
    check("sat_ovf_done", s_ovf, 1);
    mode_sel = 2'b01; start_stop = 1'b1; step(); start_stop = 1'b0;
    check("sat_restart_ovf", s_ovf, 0);
    check("sat_restart_live", s_live, 0);
    clear = 1'b1; step(); clear = 1'b0;

    // Reset mid-run discards everything.
    v0 = vcount;
    mode_sel = 2'b01; start_stop = 1'b1; step(); start_stop = 1'b0;
    repeat (24) step();
    check("mr_live_before", w_live, 2);
    reset = 1'b1; step();
    check("mr_live", w_live, 0);
    check("mr_running", w_running, 0);
    check("mr_result", w_result, 0);
    check("mr_mode", w_mode, 0);
    check("mr_ovf", w_ovf, 0);
    reset = 1'b0;
    repeat (3) step();
    check("mr_no_valid", vcount - v0, 0);
    check("mr_valid", w_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
